// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns stage sitting between ShiftRows and AddRoundKey.
// A state is accepted in IDLE, transformed COLS_PER_CYCLE columns per clock in BUSY (or passed
// through unchanged via BYPASS for the final round), then held in DONE until the sink accepts it.
//
// Optional build macro: MIX_COLUMNS_INVERSE_EN adds inv_sel and the InvMixColumns datapath.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   MixCol     in   128-bit ShiftRows state; column c = bits [127-32c -: 32], row 0 byte is MSB
//   in_valid   in   MixCol / last_round (/ inv_sel) are valid
//   in_ready   out  block can accept a state (IDLE only)
//   last_round in   1 = bypass, output equals input
//   inv_sel    in   (MIX_COLUMNS_INVERSE_EN only) 1 = InvMixColumns
//   out_valid  out  RoundOut is valid
//   out_ready  in   downstream accepts RoundOut
//   RoundOut   out  128-bit result, same byte layout as MixCol
module mix_columns_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] MixCol,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         last_round,
`ifdef MIX_COLUMNS_INVERSE_EN
  input  logic         inv_sel,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] RoundOut
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter step wraps to 0 when COLS_PER_CYCLE == 4; the increment is never used in that case.
  localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LastCol = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StBusy, StBypass, StDone} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] data_q, data_d;
  logic [1:0]   grp_idx;
  logic [6:0]   grp_base;
  logic [31:0]  old_col, new_col;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

`ifdef MIX_COLUMNS_INVERSE_EN
  logic inv_q, inv_d;

  // Returns {0E*x, 0B*x, 0D*x, 09*x}.
  function automatic logic [31:0] inv_products(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ x, x8 ^ x4 ^ x, x8 ^ x};
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [31:0] p0, p1, p2, p3;
    p0 = inv_products(col[31:24]);
    p1 = inv_products(col[23:16]);
    p2 = inv_products(col[15:8]);
    p3 = inv_products(col[7:0]);
    return {p0[31:24] ^ p1[23:16] ^ p2[15:8]  ^ p3[7:0],
            p0[7:0]   ^ p1[31:24] ^ p2[23:16] ^ p3[15:8],
            p0[15:8]  ^ p1[7:0]   ^ p2[31:24] ^ p3[23:16],
            p0[23:16] ^ p1[15:8]  ^ p2[7:0]   ^ p3[31:24]};
  endfunction
`endif

  always_comb begin
    fsm_d     = fsm_q;
    col_d     = col_q;
    data_d    = data_q;
`ifdef MIX_COLUMNS_INVERSE_EN
    inv_d     = inv_q;
`endif
    grp_idx   = '0;
    grp_base  = '0;
    old_col   = '0;
    new_col   = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    RoundOut  = '0;

    case (fsm_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d = MixCol;
`ifdef MIX_COLUMNS_INVERSE_EN
          inv_d  = inv_sel;
`endif
          fsm_d  = last_round ? StBypass : StBusy;
        end
      end
      StBusy: begin
        for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
          grp_idx  = col_q + 2'(g);
          // Column c lives at bits [(3-c)*32 +: 32]; ~c == 3-c for a 2-bit index.
          grp_base = {~grp_idx, 5'b00000};
          old_col  = data_q[grp_base +: 32];
`ifdef MIX_COLUMNS_INVERSE_EN
          new_col  = inv_q ? mix_inv(old_col) : mix_fwd(old_col);
`else
          new_col  = mix_fwd(old_col);
`endif
          data_d[grp_base +: 32] = new_col;
        end
        // Hold the counter on the last group; it is cleared only on DONE -> IDLE.
        if (col_q == LastCol) begin
          fsm_d = StDone;
        end else begin
          col_d = col_q + ColStep;
        end
      end
      StBypass: begin
        fsm_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        RoundOut  = data_q;
        if (out_ready) begin
          fsm_d = StIdle;
          col_d = '0;
        end
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= StIdle;
      col_q  <= '0;
      data_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      col_q  <= col_d;
      data_q <= data_d;
    end
  end

`ifdef MIX_COLUMNS_INVERSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end
`endif

endmodule
